// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer and main-bus arbiter between the CPU and the DMA engine.
// Optional DMG bus-conflict read-back: define OAM_DMA_BUS_CONFLICT_EN.
module oam_dma_controller #(
  parameter int          XFER_LEN        = 160,
  parameter int          CYCLES_PER_BYTE = 4,
  parameter int          START_DELAY     = 4,
  parameter logic [15:0] OAM_BASE        = 16'hFE00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write_en,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_read_en,
  input  logic        cpu_write_en,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_write_en,
  output logic [7:0]  oam_wdata,
  output logic        active
);

  localparam int PW = (CYCLES_PER_BYTE > 2) ?
                      $clog2(CYCLES_PER_BYTE) : 1;
  localparam int DW = (START_DELAY > 1) ?
                      $clog2(START_DELAY) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 1);
  localparam logic [7:0]    IDX_LAST = 8'(XFER_LEN - 1);

  // oam_addr is an offset, so OAM must start on a page boundary.
  generate
    if (CYCLES_PER_BYTE < 2 || START_DELAY < 1 ||
        XFER_LEN < 1 || XFER_LEN > 256 ||
        OAM_BASE[7:0] != 8'h00) begin : g_cfg_err
      $error("oam_dma_controller: bad parameters");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_XFER
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [7:0]    src_q, src_d;
  logic [7:0]    latch_q, latch_d;

  logic       xfer;
  logic       ph_first;
  logic       ph_last;
  logic [7:0] eff_src;

  assign xfer     = (state_q == S_XFER);
  assign ph_first = (phase_q == '0);
  assign ph_last  = (phase_q == PH_LAST);

  // 0xE0..0xFF fold down onto WRAM through the echo region.
  assign eff_src = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      phase_q <= '0;
      dcnt_q  <= '0;
      src_q   <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      dcnt_q  <= dcnt_d;
      src_q   <= src_d;
      latch_q <= latch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    dcnt_d  = dcnt_q;
    src_d   = src_q;
    latch_d = latch_q;

    unique case (state_q)
      S_DELAY: begin
        if (dcnt_q == DLY_LAST) begin
          state_d = S_XFER;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_XFER: begin
        if (ph_first) begin
          latch_d = mem_rdata;
        end
        if (ph_last) begin
          phase_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
      end
    endcase

    // A register write restarts from any state, even on the last byte.
    if (reg_write_en) begin
      src_d   = reg_wdata;
      idx_d   = '0;
      phase_d = '0;
      dcnt_d  = '0;
      state_d = S_DELAY;
    end
  end

  always_comb begin
    mem_addr     = cpu_addr;
    mem_read_en  = cpu_read_en;
    mem_write_en = cpu_write_en;
    mem_wdata    = cpu_wdata;
    cpu_rdata    = mem_rdata;
    if (xfer) begin
      mem_addr     = {eff_src, idx_q};
      mem_read_en  = ph_first;
      mem_write_en = 1'b0;
      mem_wdata    = 8'h00;
`ifdef OAM_DMA_BUS_CONFLICT_EN
      cpu_rdata    = ph_first ? mem_rdata : latch_q;
`else
      cpu_rdata    = 8'hFF;
`endif
    end
  end

  assign oam_write_en = xfer && ph_last;
  assign oam_addr     = idx_q;
  assign oam_wdata    = latch_q;
  assign active       = (state_q != S_IDLE);
  assign reg_rdata    = src_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller with a flat 64 KiB bus model.
// Expected values are hand-derived from the default parameters.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_en;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [15:0] cpu_addr;
  logic        cpu_read_en;
  logic        cpu_write_en;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  oam_addr;
  logic        oam_write_en;
  logic [7:0]  oam_wdata;
  logic        active;

  oam_dma_controller dut (
    .clk          (clk),
    .reset        (reset),
    .reg_write_en (reg_write_en),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .cpu_addr     (cpu_addr),
    .cpu_read_en  (cpu_read_en),
    .cpu_write_en (cpu_write_en),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .mem_addr     (mem_addr),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .oam_addr     (oam_addr),
    .oam_write_en (oam_write_en),
    .oam_wdata    (oam_wdata),
    .active       (active)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [7:0]  oam [0:255];
  logic [7:0]  wlog_addr [0:511];
  logic [7:0]  wlog_data [0:511];
  int          wlog_cyc  [0:511];
  logic [15:0] rlog [0:511];

  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int act_cnt = 0;
  int stray = 0;
  int n_cmp = 0;
  int n_bad = 0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc++;
    if (mem_write_en) mem[mem_addr] = mem_wdata;
  end

  always @(negedge clk) begin
    if (active) act_cnt++;
    if (oam_write_en) begin
      if (!active) stray++;
      oam[oam_addr] = oam_wdata;
      if (wr_cnt < 512) begin
        wlog_addr[wr_cnt] = oam_addr;
        wlog_data[wr_cnt] = oam_wdata;
        wlog_cyc[wr_cnt]  = cyc;
      end
      wr_cnt++;
    end
    if (active && mem_read_en) begin
      if (rd_cnt < 512) rlog[rd_cnt] = mem_addr;
      rd_cnt++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic clr();
    wr_cnt  = 0;
    rd_cnt  = 0;
    act_cnt = 0;
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
  endtask

  task automatic do_write(input logic [7:0] v, output int e);
    reg_wdata    = v;
    reg_write_en = 1'b1;
    e = cyc + 1;
    @(negedge clk); #1;
    reg_write_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (active && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, {31'd0, active}, 32'd0);
  endtask

  task automatic wait_wr(input string tag, input int target,
                         input int max);
    int n = 0;
    while (wr_cnt < target && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, wr_cnt, target);
  endtask

  logic [7:0] exp_rd;
  int w1, w2, bad;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[16'hC000 + i] = 8'(i) ^ 8'hA5;
      mem[16'hC100 + i] = 8'(i) ^ 8'h3C;
      mem[16'hC200 + i] = 8'(i) ^ 8'h96;
    end
    reset = 1'b1;
    reg_write_en = 1'b0;
    reg_wdata = 8'h00;
    cpu_addr = 16'h0000;
    cpu_read_en = 1'b0;
    cpu_write_en = 1'b0;
    cpu_wdata = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_active", {31'd0, active}, 0);
    check("rst_reg_rdata", {24'd0, reg_rdata}, 0);
    check("rst_oam_we", {31'd0, oam_write_en}, 0);
    check("rst_oam_addr", {24'd0, oam_addr}, 0);
    check("rst_oam_wdata", {24'd0, oam_wdata}, 0);
    reset = 1'b0;
    @(negedge clk); #1;

    // idle passthrough
    cpu_addr = 16'hC123;
    cpu_wdata = 8'h5A;
    cpu_write_en = 1'b1;
    #1;
    check("pt_addr", {16'd0, mem_addr}, 32'hC123);
    check("pt_we", {31'd0, mem_write_en}, 1);
    check("pt_wdata", {24'd0, mem_wdata}, 32'h5A);
    check("pt_active", {31'd0, active}, 0);
    @(negedge clk); #1;
    cpu_write_en = 1'b0;
    cpu_read_en = 1'b1;
    #1;
    check("pt_rdata", {24'd0, cpu_rdata}, 32'h5A);
    cpu_read_en = 1'b0;
    cpu_addr = 16'h0000;

    // full copy with CPU lockout
    clr();
    do_write(8'hC0, w1);
    repeat (20) @(negedge clk);
    #1;
    cpu_addr = 16'hC000;
    cpu_read_en = 1'b1;
`ifdef OAM_DMA_BUS_CONFLICT_EN
    exp_rd = 8'hA1;
`else
    exp_rd = 8'hFF;
`endif
    #1;
    check("lock_rd_ph0", {24'd0, cpu_rdata}, {24'd0, exp_rd});
    @(negedge clk); #1;
    check("lock_rd_ph1", {24'd0, cpu_rdata}, {24'd0, exp_rd});
    cpu_read_en = 1'b0;
    cpu_addr = 16'hC010;
    cpu_wdata = 8'h77;
    cpu_write_en = 1'b1;
    #1;
    check("lock_no_we", {31'd0, mem_write_en}, 0);
    @(negedge clk); #1;
    cpu_write_en = 1'b0;
    cpu_addr = 16'h0000;
    wait_idle("full_timeout", 2000);
    check("full_wr_cnt", wr_cnt, 160);
    check("full_active", act_cnt, 644);
    check("full_latency", wlog_cyc[0] + 1 - w1, 8);
    check("full_reg_rdata", {24'd0, reg_rdata}, 32'hC0);
    check("lock_wram", {24'd0, mem[16'hC010]}, 32'hB5);
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      if (wlog_addr[i] !== 8'(i)) bad++;
      if (oam[i] !== (8'(i) ^ 8'hA5)) bad++;
    end
    check("full_data", bad, 0);

    // echo mapping
    clr();
    do_write(8'hE1, w1);
    wait_idle("echo_timeout", 2000);
    check("echo_rd_cnt", rd_cnt, 160);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (rlog[i] !== (16'hC100 + 16'(i))) bad++;
    check("echo_addrs", bad, 0);
    check("echo_last", {16'd0, rlog[159]}, 32'hC19F);

    // restart mid-transfer
    clr();
    do_write(8'hC0, w1);
    wait_wr("rs_reach50", 50, 1000);
    @(negedge clk); #1;
    do_write(8'hC2, w2);
    wait_idle("rs_timeout", 2000);
    check("rs_wr_cnt", wr_cnt, 210);
    check("rs_active", act_cnt, (w2 - w1) + 644);
    check("rs_idx0", {24'd0, wlog_addr[50]}, 0);
    check("rs_data0", {24'd0, wlog_data[50]}, 32'h96);
    check("rs_latency", wlog_cyc[50] + 1 - w2, 8);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (oam[i] !== (8'(i) ^ 8'h96)) bad++;
    check("rs_data", bad, 0);

    // restart coinciding with the final OAM write
    clr();
    do_write(8'hC0, w1);
    wait_wr("fin_reach160", 160, 1000);
    do_write(8'hC1, w2);
    wait_idle("fin_timeout", 2000);
    check("fin_last_idx", {24'd0, wlog_addr[159]}, 32'd159);
    check("fin_wr_cnt", wr_cnt, 320);
    check("fin_active", act_cnt, 1288);
    check("fin_reg_rdata", {24'd0, reg_rdata}, 32'hC1);

    // reset mid-transfer
    clr();
    do_write(8'hC0, w1);
    wait_wr("rst_reach20", 20, 1000);
    reset = 1'b1;
    cpu_addr = 16'hD456;
    @(negedge clk); #1;
    check("mrst_active", {31'd0, active}, 0);
    check("mrst_oam_we", {31'd0, oam_write_en}, 0);
    check("mrst_reg_rdata", {24'd0, reg_rdata}, 0);
    check("mrst_pt_addr", {16'd0, mem_addr}, 32'hD456);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("mrst_wr_cnt", wr_cnt, 20);
    check("stray_oam_we", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
